// File: rtl/sram_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM wrapper port.
// A granted master owns the slave for a whole burst; the other master waits.
`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 32
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 4
`endif

module sram_bus_arbiter (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  // master 0
  input  logic [`BUS_ADDR_BITS-1:0] ADDR_M0,
  input  logic [`BUS_DATA_BITS-1:0] WDATA_M0,
  input  logic [`BUS_LEN_BITS-1:0]  BLEN_M0,
  input  logic                      WLAST_M0,
  input  logic                      WVALID_M0,
  input  logic                      RVALID_M0,
  output logic [`BUS_DATA_BITS-1:0] RDATA_M0,
  output logic                      RLAST_M0,
  output logic                      WREADY_M0,
  output logic                      RREADY_M0,
  // master 1
  input  logic [`BUS_ADDR_BITS-1:0] ADDR_M1,
  input  logic [`BUS_DATA_BITS-1:0] WDATA_M1,
  input  logic [`BUS_LEN_BITS-1:0]  BLEN_M1,
  input  logic                      WLAST_M1,
  input  logic                      WVALID_M1,
  input  logic                      RVALID_M1,
  output logic [`BUS_DATA_BITS-1:0] RDATA_M1,
  output logic                      RLAST_M1,
  output logic                      WREADY_M1,
  output logic                      RREADY_M1,
  // slave side
  output logic [`BUS_ADDR_BITS-1:0] ADDR_S,
  output logic [`BUS_DATA_BITS-1:0] WDATA_S,
  output logic [`BUS_LEN_BITS-1:0]  BLEN_S,
  output logic                      WLAST_S,
  output logic                      WVALID_S,
  output logic                      RVALID_S,
  input  logic [`BUS_DATA_BITS-1:0] RDATA_S,
  input  logic                      WREADY_S,
  input  logic                      RREADY_S,
  input  logic                      RLAST_S,
  // status
  output logic [1:0]                GNT,
  output logic                      BUSY,
  output logic                      dbg_state
);

  localparam int L = `BUS_LEN_BITS;
  localparam logic [0:0]   IDLE    = 1'b0;
  localparam logic [0:0]   BURST   = 1'b1;
  localparam logic [L-1:0] LEN_ONE = {{(L-1){1'b0}}, 1'b1};

  // Handshake: a beat moves on a cycle where the granted valid and the slave
  // ready are both high; valid may drop mid-burst, which simply stalls.
  logic [0:0]   state;
  logic         owner;
  logic         dir_wr;
  logic         prio;
  logic [L-1:0] len;
  logic [L-1:0] cnt;

  logic                      req0, req1, pick;
  logic [L-1:0]              pick_blen;
  logic [`BUS_ADDR_BITS-1:0] own_addr;
  logic [`BUS_DATA_BITS-1:0] own_wdata;
  logic                      own_wlast, own_wvalid, own_rvalid;
  logic                      busy_w, g_valid, s_ready, beat, last_beat, burst_end;
  logic                      unused_rlast;

  assign unused_rlast = RLAST_S;

  assign req0      = WVALID_M0 | RVALID_M0;
  assign req1      = WVALID_M1 | RVALID_M1;
  assign pick      = (req0 & req1) ? prio : req1;
  assign pick_blen = pick ? BLEN_M1 : BLEN_M0;

  assign own_addr   = owner ? ADDR_M1   : ADDR_M0;
  assign own_wdata  = owner ? WDATA_M1  : WDATA_M0;
  assign own_wlast  = owner ? WLAST_M1  : WLAST_M0;
  assign own_wvalid = owner ? WVALID_M1 : WVALID_M0;
  assign own_rvalid = owner ? RVALID_M1 : RVALID_M0;

  assign busy_w    = (state == BURST);
  assign g_valid   = dir_wr ? own_wvalid : own_rvalid;
  assign s_ready   = dir_wr ? WREADY_S : RREADY_S;
  assign beat      = busy_w & g_valid & s_ready;
  assign last_beat = (cnt == (len - LEN_ONE));
  assign burst_end = beat & (last_beat | (dir_wr & own_wlast));

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      dir_wr <= 1'b0;
      prio   <= 1'b0;
      len    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state  <= BURST;
            owner  <= pick;
            // write wins when the master raises both valids at grant
            dir_wr <= pick ? WVALID_M1 : WVALID_M0;
            len    <= (pick_blen == '0) ? LEN_ONE : pick_blen;
            cnt    <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state <= IDLE;
            prio  <= ~owner;
          end else if (beat) begin
            cnt <= cnt + LEN_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ADDR_S    = '0;
    WDATA_S   = '0;
    BLEN_S    = '0;
    WLAST_S   = 1'b0;
    WVALID_S  = 1'b0;
    RVALID_S  = 1'b0;
    RDATA_M0  = '0;
    RDATA_M1  = '0;
    RLAST_M0  = 1'b0;
    RLAST_M1  = 1'b0;
    WREADY_M0 = 1'b0;
    WREADY_M1 = 1'b0;
    RREADY_M0 = 1'b0;
    RREADY_M1 = 1'b0;
    GNT       = 2'b00;
    if (busy_w) begin
      ADDR_S   = own_addr;
      WDATA_S  = own_wdata;
      BLEN_S   = len;
      WLAST_S  = dir_wr & own_wlast;
      WVALID_S = dir_wr & own_wvalid;
      RVALID_S = ~dir_wr & own_rvalid;
      if (owner) begin
        GNT       = 2'b10;
        RDATA_M1  = RDATA_S;
        WREADY_M1 = dir_wr & WREADY_S;
        RREADY_M1 = ~dir_wr & RREADY_S;
        RLAST_M1  = ~dir_wr & RREADY_S & last_beat;
      end else begin
        GNT       = 2'b01;
        RDATA_M0  = RDATA_S;
        WREADY_M0 = dir_wr & WREADY_S;
        RREADY_M0 = ~dir_wr & RREADY_S;
        RLAST_M0  = ~dir_wr & RREADY_S & last_beat;
      end
    end
  end

  assign BUSY      = busy_w;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed table, corner sequences, then random
// traffic checked against a burst-level reference model.
`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 32
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 4
`endif

module tb_sram_bus_arbiter;

  localparam int AW = `BUS_ADDR_BITS;
  localparam int DW = `BUS_DATA_BITS;
  localparam int LW = `BUS_LEN_BITS;

  typedef struct packed {
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata_s;
    logic [LW-1:0] bl0, bl1;
    logic rv0, wv0, wl0, rv1, wv1, wl1, wr_s, rr_s;
  } in_t;

  typedef struct packed {
    in_t           in;
    logic [1:0]    gnt;
    logic          busy, rr0, rlast0;
    logic [AW-1:0] addr_s;
  } vec_t;

  logic bus_clk, bus_rst;
  logic [AW-1:0] ADDR_M0, ADDR_M1, ADDR_S;
  logic [DW-1:0] WDATA_M0, WDATA_M1, RDATA_M0, RDATA_M1, WDATA_S, RDATA_S;
  logic [LW-1:0] BLEN_M0, BLEN_M1, BLEN_S;
  logic WLAST_M0, WVALID_M0, RVALID_M0, RLAST_M0, WREADY_M0, RREADY_M0;
  logic WLAST_M1, WVALID_M1, RVALID_M1, RLAST_M1, WREADY_M1, RREADY_M1;
  logic WLAST_S, WVALID_S, RVALID_S, WREADY_S, RREADY_S, RLAST_S;
  logic [1:0] GNT;
  logic BUSY, dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [AW-1:0] exp_q[$];

  // reference model: who owns the bus and how far the burst has got
  bit m_busy, m_wr;
  int m_owner, m_len, m_done, m_prio;

  sram_bus_arbiter dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .ADDR_M0(ADDR_M0), .WDATA_M0(WDATA_M0), .BLEN_M0(BLEN_M0), .WLAST_M0(WLAST_M0),
    .WVALID_M0(WVALID_M0), .RVALID_M0(RVALID_M0), .RDATA_M0(RDATA_M0),
    .RLAST_M0(RLAST_M0), .WREADY_M0(WREADY_M0), .RREADY_M0(RREADY_M0),
    .ADDR_M1(ADDR_M1), .WDATA_M1(WDATA_M1), .BLEN_M1(BLEN_M1), .WLAST_M1(WLAST_M1),
    .WVALID_M1(WVALID_M1), .RVALID_M1(RVALID_M1), .RDATA_M1(RDATA_M1),
    .RLAST_M1(RLAST_M1), .WREADY_M1(WREADY_M1), .RREADY_M1(RREADY_M1),
    .ADDR_S(ADDR_S), .WDATA_S(WDATA_S), .BLEN_S(BLEN_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .RVALID_S(RVALID_S), .RDATA_S(RDATA_S),
    .WREADY_S(WREADY_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .GNT(GNT), .BUSY(BUSY), .dbg_state(dbg_state)
  );

  // clock / reset
  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic apply(input in_t v);
    ADDR_M0 = v.addr0; ADDR_M1 = v.addr1;
    WDATA_M0 = v.wdata0; WDATA_M1 = v.wdata1; RDATA_S = v.rdata_s;
    BLEN_M0 = v.bl0; BLEN_M1 = v.bl1;
    RVALID_M0 = v.rv0; WVALID_M0 = v.wv0; WLAST_M0 = v.wl0;
    RVALID_M1 = v.rv1; WVALID_M1 = v.wv1; WLAST_M1 = v.wl1;
    WREADY_S = v.wr_s; RREADY_S = v.rr_s; RLAST_S = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_owner = 0; m_len = 0; m_done = 0; m_prio = 0;
  endtask

  function automatic bit own_wv(); return (m_owner == 1) ? WVALID_M1 : WVALID_M0; endfunction
  function automatic bit own_rv(); return (m_owner == 1) ? RVALID_M1 : RVALID_M0; endfunction
  function automatic bit own_wl(); return (m_owner == 1) ? WLAST_M1 : WLAST_M0; endfunction

  function automatic bit model_beat();
    return m_busy && (m_wr ? (own_wv() && WREADY_S) : (own_rv() && RREADY_S));
  endfunction

  // advance the model by one rising edge using the inputs currently held
  task automatic model_step();
    bit r0, r1;
    int win, bl;
    r0 = WVALID_M0 || RVALID_M0;
    r1 = WVALID_M1 || RVALID_M1;
    if (!m_busy) begin
      if (r0 || r1) begin
        if (r0 && r1) win = m_prio;
        else win = r0 ? 0 : 1;
        m_busy = 1; m_owner = win; m_done = 0;
        m_wr = (win == 1) ? WVALID_M1 : WVALID_M0;
        bl = (win == 1) ? int'(BLEN_M1) : int'(BLEN_M0);
        m_len = (bl == 0) ? 1 : bl;
      end
    end else if (model_beat()) begin
      m_done++;
      if (m_done == m_len || (m_wr && own_wl())) begin
        m_busy = 0;
        m_prio = 1 - m_owner;
      end
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    bit o0, o1, rlast_now;
    o_addr  = (m_owner == 1) ? ADDR_M1 : ADDR_M0;
    o_wdata = (m_owner == 1) ? WDATA_M1 : WDATA_M0;
    o0 = m_busy && m_owner == 0;
    o1 = m_busy && m_owner == 1;
    rlast_now = m_busy && !m_wr && RREADY_S && (m_done == m_len - 1);
    cmp("gnt", GNT, m_busy ? (o1 ? 2 : 1) : 0);
    cmp("busy", BUSY, m_busy);
    cmp("addr_s", ADDR_S, m_busy ? o_addr : '0);
    cmp("wdata_s", WDATA_S, m_busy ? o_wdata : '0);
    cmp("blen_s", BLEN_S, m_busy ? m_len : 0);
    cmp("wlast_s", WLAST_S, m_busy && m_wr && own_wl());
    cmp("wvalid_s", WVALID_S, m_busy && m_wr && own_wv());
    cmp("rvalid_s", RVALID_S, m_busy && !m_wr && own_rv());
    cmp("wready_m0", WREADY_M0, o0 && m_wr && WREADY_S);
    cmp("wready_m1", WREADY_M1, o1 && m_wr && WREADY_S);
    cmp("rready_m0", RREADY_M0, o0 && !m_wr && RREADY_S);
    cmp("rready_m1", RREADY_M1, o1 && !m_wr && RREADY_S);
    cmp("rlast_m0", RLAST_M0, o0 && rlast_now);
    cmp("rlast_m1", RLAST_M1, o1 && rlast_now);
    cmp("rdata_m0", RDATA_M0, o0 ? RDATA_S : '0);
    cmp("rdata_m1", RDATA_M1, o1 ? RDATA_S : '0);
    // scoreboard of slave-side beats, keyed by address
    if (model_beat()) exp_q.push_back(o_addr);
    if ((WVALID_S && WREADY_S) || (RVALID_S && RREADY_S)) begin
      if (exp_q.size() == 0) cmp("sb_unexpected_beat", 1, 0);
      else cmp("sb_addr", ADDR_S, exp_q.pop_front());
    end
  endtask

  task automatic drive_and_check(input in_t v);
    apply(v);
    #1;
    check_outputs();
  endtask

  task automatic finish_cycle();
    @(posedge bus_clk);
    model_step();
    @(negedge bus_clk);
  endtask

  task automatic do_reset();
    in_t z;
    z = '0;
    apply(z);
    bus_rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge bus_clk);
    @(negedge bus_clk);
    bus_rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic rv0, input logic [AW-1:0] a0, input logic [1:0] g,
                              input logic b, input logic r, input logic l, input logic [AW-1:0] as);
    vec_t v;
    v = '0;
    v.in.rv0 = rv0; v.in.bl0 = 4; v.in.addr0 = a0; v.in.rr_s = 1'b1;
    v.in.rdata_s = 32'hA5A5_0000 | a0;
    v.gnt = g; v.busy = b; v.rr0 = r; v.rlast0 = l; v.addr_s = as;
    return v;
  endfunction

  initial begin
    vec_t tbl[6];
    in_t  v;
    logic [1:0] e_gnt[6];

    bus_rst = 1'b1;
    v = '0;
    apply(v);
    model_reset();
    @(negedge bus_clk);

    // four-beat read from master 0, addresses 0x10..0x13
    tbl[0] = mk(1'b1, 32'h10, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[1] = mk(1'b1, 32'h10, 2'b01, 1'b1, 1'b1, 1'b0, 32'h10);
    tbl[2] = mk(1'b1, 32'h11, 2'b01, 1'b1, 1'b1, 1'b0, 32'h11);
    tbl[3] = mk(1'b1, 32'h12, 2'b01, 1'b1, 1'b1, 1'b0, 32'h12);
    tbl[4] = mk(1'b1, 32'h13, 2'b01, 1'b1, 1'b1, 1'b1, 32'h13);
    tbl[5] = mk(1'b0, 32'h14, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_and_check(tbl[i].in);
      cmp($sformatf("tbl%0d_gnt", i), GNT, tbl[i].gnt);
      cmp($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
      cmp($sformatf("tbl%0d_rready0", i), RREADY_M0, tbl[i].rr0);
      cmp($sformatf("tbl%0d_rlast0", i), RLAST_M0, tbl[i].rlast0);
      cmp($sformatf("tbl%0d_addr_s", i), ADDR_S, tbl[i].addr_s);
      finish_cycle();
    end

    // simultaneous requests after reset: M0 first, M1 right after the idle cycle
    do_reset();
    v = '0; v.rv0 = 1; v.rv1 = 1; v.bl0 = 2; v.bl1 = 2; v.rr_s = 1;
    v.addr0 = 32'h100; v.addr1 = 32'h200;
    e_gnt[0] = 2'b00; e_gnt[1] = 2'b01; e_gnt[2] = 2'b01;
    e_gnt[3] = 2'b00; e_gnt[4] = 2'b10; e_gnt[5] = 2'b10;
    for (int i = 0; i < 6; i++) begin
      drive_and_check(v);
      cmp($sformatf("rr%0d_gnt", i), GNT, e_gnt[i]);
      finish_cycle();
    end

    // M1 write of 8 beats cut short by WLAST on beat 3
    do_reset();
    v = '0; v.wv1 = 1; v.bl1 = 8; v.wr_s = 1; v.addr1 = 32'h300;
    for (int i = 0; i < 5; i++) begin
      v.wl1 = (i == 3);
      v.wv1 = (i < 4);
      v.wdata1 = $urandom;
      drive_and_check(v);
      if (i >= 1 && i <= 3) cmp($sformatf("wl%0d_wready1", i), WREADY_M1, 1);
      if (i == 4) begin
        cmp("wl_after_wvalid_s", WVALID_S, 0);
        cmp("wl_after_gnt", GNT, 0);
      end
      finish_cycle();
    end

    // zero-length read is one beat with RLAST
    do_reset();
    v = '0; v.rv0 = 1; v.bl0 = 0; v.rr_s = 1; v.addr0 = 32'h40;
    drive_and_check(v);
    finish_cycle();
    drive_and_check(v);
    cmp("len0_rlast0", RLAST_M0, 1);
    cmp("len0_blen_s", BLEN_S, 1);
    finish_cycle();
    v.rv0 = 0;
    drive_and_check(v);
    cmp("len0_idle_busy", BUSY, 0);
    finish_cycle();

    // owner stalls for three cycles while M1 keeps requesting
    do_reset();
    v = '0; v.rv0 = 1; v.bl0 = 4; v.rv1 = 1; v.bl1 = 1; v.rr_s = 1;
    v.addr0 = 32'h500; v.addr1 = 32'h600;
    for (int i = 0; i < 10; i++) begin
      v.rv0 = !(i >= 3 && i <= 5) && (i < 8);
      drive_and_check(v);
      if (i >= 3 && i <= 5) begin
        cmp($sformatf("stall%0d_gnt", i), GNT, 2'b01);
        cmp($sformatf("stall%0d_rready1", i), RREADY_M1, 0);
        cmp($sformatf("stall%0d_rvalid_s", i), RVALID_S, 0);
      end
      if (i == 7) cmp("stall_last_rlast0", RLAST_M0, 1);
      if (i == 9) cmp("stall_then_m1_gnt", GNT, 2'b10);
      finish_cycle();
    end

    // reset pulsed during beat 2 of a write burst
    do_reset();
    v = '0; v.wv0 = 1; v.bl0 = 4; v.wr_s = 1; v.addr0 = 32'h700;
    drive_and_check(v);
    finish_cycle();
    drive_and_check(v);
    finish_cycle();
    drive_and_check(v);
    #1;
    bus_rst = 1'b1;
    #1;
    cmp("rst_wvalid_s", WVALID_S, 0);
    cmp("rst_gnt", GNT, 0);
    cmp("rst_busy", BUSY, 0);
    cmp("rst_wready0", WREADY_M0, 0);
    model_reset();
    @(posedge bus_clk);
    @(negedge bus_clk);
    bus_rst = 1'b0;
    v.wv1 = 1; v.bl1 = 2; v.addr1 = 32'h800;
    drive_and_check(v);
    finish_cycle();
    drive_and_check(v);
    cmp("rst_next_gnt_m0", GNT, 2'b01);
    finish_cycle();

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v.rv0 = ($urandom_range(0, 3) != 0);
      v.wv0 = ($urandom_range(0, 2) == 0);
      v.wl0 = ($urandom_range(0, 5) == 0);
      v.rv1 = ($urandom_range(0, 3) != 0);
      v.wv1 = ($urandom_range(0, 2) == 0);
      v.wl1 = ($urandom_range(0, 5) == 0);
      v.bl0 = LW'($urandom_range(0, (1 << LW) - 1));
      v.bl1 = LW'($urandom_range(0, (1 << LW) - 1));
      v.wr_s = ($urandom_range(0, 3) != 0);
      v.rr_s = ($urandom_range(0, 3) != 0);
      v.addr0 = $urandom; v.addr1 = $urandom;
      v.wdata0 = $urandom; v.wdata1 = $urandom; v.rdata_s = $urandom;
      drive_and_check(v);
      finish_cycle();
    end

    cmp("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
